// File: rtl/spiht_ingest_pkg.sv
// ---------------------------------------------------------------------------
// spiht_ingest_pkg
//   Shared definitions for the pixel ingest slice:
//     - ingest_state_t : capture FSM state encoding
//     - DEF_*          : default image geometry
//     - ingest_aw()    : bank address width for a given line width / strip
// ---------------------------------------------------------------------------
package spiht_ingest_pkg;

   localparam int unsigned DEF_IMG_WIDTH   = 8192;
   localparam int unsigned DEF_IMG_HEIGHT  = 8192;
   localparam int unsigned DEF_STRIP_LINES = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // before first line of a frame / after frame end
      ST_LINE = 2'd1,   // HSYNC high, pixels being written
      ST_GAP  = 2'd2,   // between lines of a frame
      ST_DROP = 2'd3    // target bank still full, current line discarded
   } ingest_state_t;

   // One bank holds a whole strip of lines.
   function automatic int unsigned ingest_aw(input int unsigned width,
                                             input int unsigned lines);
      return (width * lines > 1) ? $clog2(width * lines) : 1;
   endfunction

endpackage

// File: rtl/ingest_bank_tracker.sv
// ---------------------------------------------------------------------------
// ingest_bank_tracker
//   Tracks which ping-pong bank is full and hands full banks to the encoder
//   one at a time.
//
//   PCLK        in   clock
//   RST         in   asynchronous reset, active low
//   strip_done  in   a strip was just completed into strip_bank
//   strip_bank  in   bank that strip_done refers to
//   enc_done    in   encoder finished the bank on enc_bank (ignored if idle)
//   bank_full   out  per-bank full flags
//   enc_start   out  one-cycle dispatch pulse
//   enc_bank    out  bank being (or last) dispatched
// ---------------------------------------------------------------------------
module ingest_bank_tracker
   import spiht_ingest_pkg::*;
(
   input  logic       PCLK,
   input  logic       RST,
   input  logic       strip_done,
   input  logic       strip_bank,
   input  logic       enc_done,
   output logic [1:0] bank_full,
   output logic       enc_start,
   output logic       enc_bank
);

   logic       busy;
   logic [1:0] full_nxt;

   // Release and fill can land in the same cycle; both are applied.
   always_comb begin
      full_nxt = bank_full;
      if (enc_done && busy)
         full_nxt[enc_bank] = 1'b0;
      if (strip_done)
         full_nxt[strip_bank] = 1'b1;
   end

   // Dispatch looks at the registered flags, so a bank filled or released
   // on this edge is considered on the next one.
   always_ff @(posedge PCLK or negedge RST) begin
      if (!RST) begin
         bank_full <= '0;
         busy      <= 1'b0;
         enc_start <= 1'b0;
         enc_bank  <= 1'b0;
      end else begin
         bank_full <= full_nxt;
         enc_start <= 1'b0;
         if (busy) begin
            if (enc_done)
               busy <= 1'b0;
         end else if (|bank_full) begin
            enc_start <= 1'b1;
            enc_bank  <= ~bank_full[0];   // bank 0 wins when both are full
            busy      <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_ingest_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_ingest_ctrl
//   Captures a line-synchronous pixel stream into a ping-pong strip buffer
//   and dispatches completed strips to the encoder.
//
//   Parameters: IMG_WIDTH (pixels/line), IMG_HEIGHT (lines/frame),
//               STRIP_LINES (lines/bank), AW (bank address width)
//
//   PCLK        in   clock
//   RST         in   asynchronous reset, active low
//   HSYNC       in   line valid
//   Pixel_DATA  in   16-bit pixel
//   enc_done    in   encoder consumed current bank (pulse)
//   wr_en       out  buffer write strobe (one cycle after the pixel)
//   wr_bank     out  bank being written
//   wr_addr     out  line_in_strip*IMG_WIDTH + pixel index
//   wr_data     out  pixel to write
//   enc_start   out  encoder dispatch pulse
//   enc_bank    out  bank handed to encoder
//   frame_done  out  pulse after the last line of a frame
//   line_err    out  pulse after a line whose length != IMG_WIDTH
//   overflow    out  sticky: a line was dropped because its bank was full
//
//   Build option: define INGEST_LINE_CHECK_EN to enable line_err; otherwise
//   line_err is constant 0.
// ---------------------------------------------------------------------------
module pixel_ingest_ctrl
   import spiht_ingest_pkg::*;
#(
   parameter int unsigned IMG_WIDTH   = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT,
   parameter int unsigned STRIP_LINES = DEF_STRIP_LINES,
   parameter int unsigned AW          = ingest_aw(IMG_WIDTH, STRIP_LINES)
)(
   input  logic          PCLK,
   input  logic          RST,
   input  logic          HSYNC,
   input  logic [15:0]   Pixel_DATA,
   input  logic          enc_done,
   output logic          wr_en,
   output logic          wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic [15:0]   wr_data,
   output logic          enc_start,
   output logic          enc_bank,
   output logic          frame_done,
   output logic          line_err,
   output logic          overflow
);

   // Pixel counter saturates one past IMG_WIDTH so long lines stay visible.
   localparam int unsigned PW = $clog2(IMG_WIDTH + 2);
   localparam int unsigned LW = (STRIP_LINES > 1) ? $clog2(STRIP_LINES) : 1;
   localparam int unsigned FW = $clog2(IMG_HEIGHT + 1);

   localparam logic [PW-1:0] PIX_FULL        = PW'(IMG_WIDTH);
   localparam logic [PW-1:0] PIX_SAT         = PW'(IMG_WIDTH + 1);
   localparam logic [LW-1:0] LAST_STRIP_LINE = LW'(STRIP_LINES - 1);
   localparam logic [FW-1:0] LAST_FRAME_LINE = FW'(IMG_HEIGHT - 1);
   localparam logic [AW-1:0] LINE_STEP       = AW'(IMG_WIDTH);

   generate
      if ((IMG_HEIGHT % STRIP_LINES) != 0) begin : g_bad_geometry
         $error("pixel_ingest_ctrl: IMG_HEIGHT must be a multiple of STRIP_LINES");
      end
   endgenerate

   ingest_state_t state, state_nxt;

   logic          hsync_q;
   logic [PW-1:0] pix_cnt;
   logic [LW-1:0] line_in_strip;
   logic [AW-1:0] line_base;      // line_in_strip*IMG_WIDTH, kept incrementally
   logic [FW-1:0] frame_cnt;
   logic [1:0]    bank_full;

   logic          rise, fall;
   logic          do_write, line_end, drop_start, strip_end, frame_end;
   logic [AW-1:0] pix_addr;

   assign rise = HSYNC & ~hsync_q;
   assign fall = ~HSYNC & hsync_q;

   // -----------------------------------------------------------------------
   // Capture FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge PCLK or negedge RST) begin
      if (!RST)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      do_write   = 1'b0;
      line_end   = 1'b0;
      drop_start = 1'b0;
      unique case (state)
         ST_IDLE, ST_GAP: begin
            if (rise) begin
               if (bank_full[wr_bank]) begin
                  state_nxt  = ST_DROP;
                  drop_start = 1'b1;
               end else begin
                  state_nxt = ST_LINE;
                  do_write  = 1'b1;
               end
            end
         end
         ST_LINE: begin
            if (fall) begin
               line_end  = 1'b1;
               state_nxt = (frame_cnt == LAST_FRAME_LINE) ? ST_IDLE : ST_GAP;
            end else if (HSYNC && (pix_cnt < PIX_FULL)) begin
               do_write = 1'b1;
            end
         end
         ST_DROP: begin
            // Dropped line is not counted towards strip or frame.
            if (fall)
               state_nxt = ST_GAP;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign strip_end = line_end && (line_in_strip == LAST_STRIP_LINE);
   assign frame_end = line_end && (frame_cnt == LAST_FRAME_LINE);

   // First pixel of a line is always at offset 0 of the line.
   assign pix_addr = (state == ST_LINE) ? AW'(pix_cnt) : '0;

   // -----------------------------------------------------------------------
   // Write port, counters, status
   // -----------------------------------------------------------------------
   always_ff @(posedge PCLK or negedge RST) begin
      if (!RST) begin
         hsync_q       <= 1'b0;
         wr_en         <= 1'b0;
         wr_bank       <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         pix_cnt       <= '0;
         line_in_strip <= '0;
         line_base     <= '0;
         frame_cnt     <= '0;
         frame_done    <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         hsync_q    <= HSYNC;
         wr_en      <= do_write;
         frame_done <= frame_end;

         if (do_write) begin
            wr_data <= Pixel_DATA;
            wr_addr <= line_base + pix_addr;
         end

         if (do_write && (state != ST_LINE))
            pix_cnt <= PW'(1);
         else if ((state == ST_LINE) && HSYNC && (pix_cnt != PIX_SAT))
            pix_cnt <= pix_cnt + 1'b1;

         if (drop_start)
            overflow <= 1'b1;

         if (line_end) begin
            if (strip_end) begin
               line_in_strip <= '0;
               line_base     <= '0;
               wr_bank       <= ~wr_bank;
            end else begin
               line_in_strip <= line_in_strip + 1'b1;
               line_base     <= line_base + LINE_STEP;
            end
            if (frame_end) begin
               frame_cnt <= '0;
               pix_cnt   <= '0;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

`ifdef INGEST_LINE_CHECK_EN
   always_ff @(posedge PCLK or negedge RST) begin
      if (!RST)
         line_err <= 1'b0;
      else
         line_err <= line_end && (pix_cnt != PIX_FULL);
   end
`else
   assign line_err = 1'b0;
`endif

   // -----------------------------------------------------------------------
   // Bank full flags and encoder dispatch
   // -----------------------------------------------------------------------
   ingest_bank_tracker u_bank_tracker (
      .PCLK       (PCLK),
      .RST        (RST),
      .strip_done (strip_end),
      .strip_bank (wr_bank),
      .enc_done   (enc_done),
      .bank_full  (bank_full),
      .enc_start  (enc_start),
      .enc_bank   (enc_bank)
   );

endmodule

// File: tb/tb_pixel_ingest_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pixel_ingest_ctrl
//   Self-checking bench for pixel_ingest_ctrl with IMG_WIDTH=8,
//   STRIP_LINES=2, IMG_HEIGHT=4. Expected writes are queued as pixels are
//   driven and popped by a monitor when wr_en is seen.
// ---------------------------------------------------------------------------
module tb_pixel_ingest_ctrl;

   localparam int unsigned W   = 8;
   localparam int unsigned S   = 2;
   localparam int unsigned H   = 4;
   localparam int unsigned AWB = 4;

   logic            PCLK = 1'b0;
   logic            RST;
   logic            HSYNC;
   logic [15:0]     Pixel_DATA;
   logic            enc_done;
   logic            wr_en;
   logic            wr_bank;
   logic [AWB-1:0]  wr_addr;
   logic [15:0]     wr_data;
   logic            enc_start;
   logic            enc_bank;
   logic            frame_done;
   logic            line_err;
   logic            overflow;

   always #5 PCLK = ~PCLK;

   pixel_ingest_ctrl #(
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H),
      .STRIP_LINES (S),
      .AW          (AWB)
   ) dut (
      .PCLK       (PCLK),
      .RST        (RST),
      .HSYNC      (HSYNC),
      .Pixel_DATA (Pixel_DATA),
      .enc_done   (enc_done),
      .wr_en      (wr_en),
      .wr_bank    (wr_bank),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .enc_start  (enc_start),
      .enc_bank   (enc_bank),
      .frame_done (frame_done),
      .line_err   (line_err),
      .overflow   (overflow)
   );

   typedef struct {
      logic [AWB-1:0] addr;
      logic [15:0]    data;
      logic           bank;
      int unsigned    edge_n;
   } wr_exp_t;

   typedef struct {
      logic        bank;
      int unsigned edge_n;
   } enc_obs_t;

   wr_exp_t     exp_q[$];
   enc_obs_t    enc_log[$];
   int unsigned cycle        = 0;
   int unsigned n_cmp        = 0;
   int unsigned n_bad        = 0;
   int unsigned n_writes     = 0;
   int unsigned n_line_err   = 0;
   int unsigned n_frame_done = 0;

`ifdef INGEST_LINE_CHECK_EN
   localparam int unsigned EXP_LEN_ERRS = 2;
`else
   localparam int unsigned EXP_LEN_ERRS = 0;
`endif

   always @(posedge PCLK) cycle++;

   // Monitor: scoreboard pop on every write, plus event logging.
   always @(negedge PCLK) begin
      wr_exp_t e;
      if (wr_en === 1'b1) begin
         n_writes++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL write_unexpected: got addr=%0d data=%h bank=%0d at edge %0d, required no write",
                     wr_addr, wr_data, wr_bank, cycle);
         end else begin
            e = exp_q.pop_front();
            if (wr_addr !== e.addr || wr_data !== e.data || wr_bank !== e.bank || cycle != e.edge_n) begin
               n_bad++;
               $display("FAIL write_match: got addr=%0d data=%h bank=%0d edge=%0d, required addr=%0d data=%h bank=%0d edge=%0d",
                        wr_addr, wr_data, wr_bank, cycle, e.addr, e.data, e.bank, e.edge_n);
            end
         end
      end
      if (enc_start === 1'b1) enc_log.push_back('{bank: enc_bank, edge_n: cycle});
      if (line_err === 1'b1) n_line_err++;
      if (frame_done === 1'b1) n_frame_done++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change 2 time units after a rising edge; sampled on the next one.
   task automatic drive(input logic h, input logic [15:0] d, input logic done);
      @(posedge PCLK);
      #2;
      HSYNC      = h;
      Pixel_DATA = d;
      enc_done   = done;
   endtask

   task automatic settle(input int unsigned n);
      repeat (n) drive(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic send_line(input int unsigned n, input logic [15:0] d0,
                            input logic [AWB-1:0] a0, input logic bank, input bit expect_wr);
      for (int unsigned i = 0; i < n; i++) begin
         drive(1'b1, d0 + 16'(i), 1'b0);
         if (expect_wr && i < W)
            exp_q.push_back('{addr: a0 + AWB'(i), data: d0 + 16'(i), bank: bank, edge_n: cycle + 1});
      end
      drive(1'b0, 16'h0000, 1'b0);
      drive(1'b0, 16'h0000, 1'b0);
      drive(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge PCLK);
      #2;
      RST        = 1'b0;
      HSYNC      = 1'b0;
      Pixel_DATA = 16'h0000;
      enc_done   = 1'b0;
      repeat (2) @(posedge PCLK);
      #2;
      RST = 1'b1;
      enc_log.delete();
   endtask

   task automatic test_reset();
      logic [AWB+23:0] got;
      RST = 1'b0; HSYNC = 1'b0; Pixel_DATA = 16'h0000; enc_done = 1'b0;
      repeat (3) @(negedge PCLK);
      got = {wr_en, wr_bank, wr_addr, wr_data, enc_start, enc_bank, frame_done, line_err, overflow};
      n_cmp++;
      if (got !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h, required 0", got);
      end
      @(posedge PCLK);
      #2;
      RST = 1'b1;
   endtask

   task automatic test_single_line();
      int unsigned wb;
      do_reset();
      wb = n_writes;
      send_line(8, 16'h0010, 4'd0, 1'b0, 1'b1);
      settle(1);
      n_cmp++;
      if (n_writes - wb != 8) begin
         n_bad++; $display("FAIL single_line_count: got %0d writes, required 8", n_writes - wb);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL single_line_pending: got %0d outstanding, required 0", exp_q.size());
      end
      n_cmp++;
      if (enc_log.size() != 0) begin
         n_bad++; $display("FAIL single_line_dispatch: got %0d enc_start, required 0", enc_log.size());
      end
   endtask

   task automatic test_two_lines();
      send_line(8, 16'h0020, 4'd8, 1'b0, 1'b1);
      n_cmp++;
      if (wr_bank !== 1'b1) begin
         n_bad++; $display("FAIL two_lines_wr_bank: got %0d, required 1", wr_bank);
      end
      settle(3);
      n_cmp++;
      if (enc_log.size() != 1 || enc_log[0].bank !== 1'b0) begin
         n_bad++; $display("FAIL two_lines_dispatch: got %0d pulses, required 1 for bank 0", enc_log.size());
      end
      n_cmp++;
      if (n_line_err != 0) begin
         n_bad++; $display("FAIL two_lines_line_err: got %0d, required 0", n_line_err);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL two_lines_pending: got %0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_overflow();
      int unsigned fd, wb;
      fd = n_frame_done;
      send_line(8, 16'h0030, 4'd0, 1'b1, 1'b1);
      send_line(8, 16'h0040, 4'd8, 1'b1, 1'b1);
      settle(3);
      n_cmp++;
      if (n_frame_done - fd != 1) begin
         n_bad++; $display("FAIL frame_done_count: got %0d, required 1", n_frame_done - fd);
      end
      n_cmp++;
      if (enc_log.size() != 1) begin
         n_bad++; $display("FAIL busy_no_dispatch: got %0d pulses, required 1", enc_log.size());
      end
      n_cmp++;
      if (wr_bank !== 1'b0 || overflow !== 1'b0) begin
         n_bad++; $display("FAIL frame_end_state: got bank=%0d ovf=%0d, required bank=0 ovf=0", wr_bank, overflow);
      end
      wb = n_writes;
      send_line(8, 16'h0050, 4'd0, 1'b0, 1'b0);
      settle(1);
      n_cmp++;
      if (overflow !== 1'b1 || n_writes != wb) begin
         n_bad++; $display("FAIL drop_line: got ovf=%0d writes=%0d, required ovf=1 writes=0", overflow, n_writes - wb);
      end
      drive(1'b0, 16'h0000, 1'b1);
      settle(3);
      n_cmp++;
      if (enc_log.size() != 2 || enc_log[enc_log.size()-1].bank !== 1'b1) begin
         n_bad++; $display("FAIL queued_dispatch: got %0d pulses, required 2 with last bank 1", enc_log.size());
      end
      drive(1'b0, 16'h0000, 1'b1);
      settle(2);
      drive(1'b0, 16'h0000, 1'b1);   // encoder idle: must be ignored
      settle(3);
      n_cmp++;
      if (enc_log.size() != 2) begin
         n_bad++; $display("FAIL idle_done_ignored: got %0d pulses, required 2", enc_log.size());
      end
      send_line(8, 16'h0058, 4'd0, 1'b0, 1'b1);
      settle(1);
      n_cmp++;
      if (overflow !== 1'b1 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL overflow_sticky: got ovf=%0d pending=%0d, required ovf=1 pending=0", overflow, exp_q.size());
      end
   endtask

   task automatic test_done_collision();
      int unsigned f;
      do_reset();
      send_line(8, 16'h0060, 4'd0, 1'b0, 1'b1);
      send_line(8, 16'h0070, 4'd8, 1'b0, 1'b1);
      send_line(8, 16'h0080, 4'd0, 1'b1, 1'b1);
      for (int unsigned i = 0; i < 8; i++) begin
         drive(1'b1, 16'h0090 + 16'(i), 1'b0);
         exp_q.push_back('{addr: 4'd8 + AWB'(i), data: 16'h0090 + 16'(i), bank: 1'b1, edge_n: cycle + 1});
      end
      drive(1'b0, 16'h0000, 1'b1);     // line end and enc_done together
      f = cycle + 1;
      drive(1'b0, 16'h0000, 1'b0);
      settle(3);
      n_cmp++;
      if (enc_log.size() != 2 || enc_log[enc_log.size()-1].bank !== 1'b1 ||
          enc_log[enc_log.size()-1].edge_n != f + 1) begin
         n_bad++;
         $display("FAIL collision_dispatch: got %0d pulses last bank=%0d edge=%0d, required 2 pulses bank=1 edge=%0d",
                  enc_log.size(), enc_log[enc_log.size()-1].bank, enc_log[enc_log.size()-1].edge_n, f + 1);
      end
      send_line(8, 16'h00A0, 4'd0, 1'b0, 1'b1);
      settle(1);
      n_cmp++;
      if (overflow !== 1'b0 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL collision_bank0_free: got ovf=%0d pending=%0d, required 0 and 0", overflow, exp_q.size());
      end
   endtask

   task automatic test_line_len();
      int unsigned le, wb;
      do_reset();
      le = n_line_err;
      wb = n_writes;
      send_line(6,  16'h0100, 4'd0, 1'b0, 1'b1);
      send_line(10, 16'h0200, 4'd8, 1'b0, 1'b1);
      settle(2);
      n_cmp++;
      if (n_line_err - le != EXP_LEN_ERRS) begin
         n_bad++; $display("FAIL line_err_count: got %0d, required %0d", n_line_err - le, EXP_LEN_ERRS);
      end
      n_cmp++;
      if (n_writes - wb != 14 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL long_line_clamp: got %0d writes pending=%0d, required 14 and 0", n_writes - wb, exp_q.size());
      end
   endtask

   task automatic test_reset_midline();
      logic [AWB+23:0] got;
      do_reset();
      send_line(8, 16'h0300, 4'd0, 1'b0, 1'b1);
      send_line(8, 16'h0310, 4'd8, 1'b0, 1'b1);
      for (int unsigned i = 0; i < 4; i++) begin
         drive(1'b1, 16'h0320 + 16'(i), 1'b0);
         exp_q.push_back('{addr: AWB'(i), data: 16'h0320 + 16'(i), bank: 1'b1, edge_n: cycle + 1});
      end
      @(posedge PCLK);
      @(negedge PCLK);
      #1;
      RST = 1'b0;                      // HSYNC still high: mid-line, mid-encode
      @(posedge PCLK);
      #1;
      got = {wr_en, wr_bank, wr_addr, wr_data, enc_start, enc_bank, frame_done, line_err, overflow};
      n_cmp++;
      if (got !== '0 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL midline_reset: got %h pending=%0d, required 0 and 0", got, exp_q.size());
      end
      HSYNC = 1'b0;
      @(posedge PCLK);
      #2;
      RST = 1'b1;
      enc_log.delete();
      settle(2);
      send_line(8, 16'h0400, 4'd0, 1'b0, 1'b1);
      settle(2);
      n_cmp++;
      if (exp_q.size() != 0 || enc_log.size() != 0 || overflow !== 1'b0) begin
         n_bad++; $display("FAIL fresh_frame: got pending=%0d pulses=%0d ovf=%0d, required 0 0 0",
                           exp_q.size(), enc_log.size(), overflow);
      end
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_two_lines();
      test_overflow();
      test_done_collision();
      test_line_len();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
